m00_axi_arbiter: RTL

Two-into-one AXI4 master arbiter that shares the single `m00_axi` port of the Zynq PL shell between two requesters, for example the BlackParrot DMA engine and a host-driven debug mover. Read and write address channels are arbitrated independently with round-robin priority. W data is ordered by a grant FIFO, and B/R responses are routed back by a source tag carried in the ID MSB. The block sits between the requesters and the `m00_axi_*` top-level ports, and all logic runs on `aclk`.

---
 rtl/m00_axi_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/m00_axi_arbiter.sv
// Two-into-one AXI4 master arbiter sharing the m00_axi port between two requesters.
// AW and AR are arbitrated independently (round-robin). W is ordered by a FIFO of
// granted write IDs, and B/R are routed back by ID bit 5 (source tag).

// Round-robin address-channel arbiter with an outstanding-transaction counter.
module m00_axi_arbiter_rr #(
  parameter int max_outstanding_p = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic valid0,
  input  logic valid1,
  input  logic blocked,
  input  logic m_ready,
  input  logic dec,
  output logic sel,
  output logic m_valid,
  output logic ready0,
  output logic ready1,
  output logic hs
);
  localparam int CW = $clog2(max_outstanding_p) + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state;
  logic            lock_src;
  logic            prio;
  logic [CW-1:0]   cnt;
  logic            at_max;
  logic            block;
  logic            sel_valid;

  assign at_max    = (cnt == CW'(max_outstanding_p));
  assign block     = at_max | blocked;
  assign sel_valid = sel ? valid1 : valid0;
  assign m_valid   = sel_valid & ~block;
  assign ready0    = m_valid & m_ready & ~sel;
  assign ready1    = m_valid & m_ready & sel;
  assign hs        = m_valid & m_ready;

  // Winner: locked source while stalled, else the requester, prio breaks ties.
  always_comb begin
    sel = 1'b0;
    if (state == ST_LOCKED)    sel = lock_src;
    else if (valid0 && valid1) sel = prio;
    else                       sel = valid1;
  end

  // Lock on a stalled valid, rotate priority on handshake, track outstanding count.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      lock_src <= 1'b0;
      prio     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (m_valid && !m_ready) begin
          state    <= ST_LOCKED;
          lock_src <= sel;
        end
        ST_LOCKED: if (hs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (hs) prio <= ~sel;
      if (hs && !dec && !at_max)            cnt <= cnt + CW'(1);
      else if (dec && !hs && cnt != '0)     cnt <= cnt - CW'(1);
    end
  end

  // Counter over/underflow means a requester or the slave broke the protocol.
  always_ff @(posedge aclk) begin
    if (!areset) begin
      assert (!(dec && !hs && cnt == '0));
      assert (!(hs && !dec && at_max));
    end
  end
endmodule

module m00_axi_arbiter #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int max_outstanding_p    = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
  // requester 0
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic [4:0]                        s0_axi_awid,
  input  logic [7:0]                        s0_axi_awlen,
  input  logic [2:0]                        s0_axi_awsize,
  input  logic [1:0]                        s0_axi_awburst,
  input  logic                              s0_axi_awlock,
  input  logic [3:0]                        s0_axi_awcache,
  input  logic [2:0]                        s0_axi_awprot,
  input  logic [3:0]                        s0_axi_awqos,
  input  logic                              s0_axi_awvalid,
  output logic                              s0_axi_awready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                              s0_axi_wlast,
  input  logic                              s0_axi_wvalid,
  output logic                              s0_axi_wready,
  output logic                              s0_axi_bvalid,
  output logic [4:0]                        s0_axi_bid,
  output logic [1:0]                        s0_axi_bresp,
  input  logic                              s0_axi_bready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic [4:0]                        s0_axi_arid,
  input  logic [7:0]                        s0_axi_arlen,
  input  logic [2:0]                        s0_axi_arsize,
  input  logic [1:0]                        s0_axi_arburst,
  input  logic                              s0_axi_arlock,
  input  logic [3:0]                        s0_axi_arcache,
  input  logic [2:0]                        s0_axi_arprot,
  input  logic [3:0]                        s0_axi_arqos,
  input  logic                              s0_axi_arvalid,
  output logic                              s0_axi_arready,
  output logic                              s0_axi_rvalid,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [4:0]                        s0_axi_rid,
  output logic                              s0_axi_rlast,
  output logic [1:0]                        s0_axi_rresp,
  input  logic                              s0_axi_rready,
  // requester 1
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic [4:0]                        s1_axi_awid,
  input  logic [7:0]                        s1_axi_awlen,
  input  logic [2:0]                        s1_axi_awsize,
  input  logic [1:0]                        s1_axi_awburst,
  input  logic                              s1_axi_awlock,
  input  logic [3:0]                        s1_axi_awcache,
  input  logic [2:0]                        s1_axi_awprot,
  input  logic [3:0]                        s1_axi_awqos,
  input  logic                              s1_axi_awvalid,
  output logic                              s1_axi_awready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                              s1_axi_wlast,
  input  logic                              s1_axi_wvalid,
  output logic                              s1_axi_wready,
  output logic                              s1_axi_bvalid,
  output logic [4:0]                        s1_axi_bid,
  output logic [1:0]                        s1_axi_bresp,
  input  logic                              s1_axi_bready,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic [4:0]                        s1_axi_arid,
  input  logic [7:0]                        s1_axi_arlen,
  input  logic [2:0]                        s1_axi_arsize,
  input  logic [1:0]                        s1_axi_arburst,
  input  logic                              s1_axi_arlock,
  input  logic [3:0]                        s1_axi_arcache,
  input  logic [2:0]                        s1_axi_arprot,
  input  logic [3:0]                        s1_axi_arqos,
  input  logic                              s1_axi_arvalid,
  output logic                              s1_axi_arready,
  output logic                              s1_axi_rvalid,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [4:0]                        s1_axi_rid,
  output logic                              s1_axi_rlast,
  output logic [1:0]                        s1_axi_rresp,
  input  logic                              s1_axi_rready,
  // shared master port
  output logic [5:0]                        m00_axi_awid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]                        m00_axi_awlen,
  output logic [2:0]                        m00_axi_awsize,
  output logic [1:0]                        m00_axi_awburst,
  output logic                              m00_axi_awlock,
  output logic [3:0]                        m00_axi_awcache,
  output logic [2:0]                        m00_axi_awprot,
  output logic [3:0]                        m00_axi_awqos,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [5:0]                        m00_axi_wid,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wlast,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [5:0]                        m00_axi_bid,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [5:0]                        m00_axi_arid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]                        m00_axi_arlen,
  output logic [2:0]                        m00_axi_arsize,
  output logic [1:0]                        m00_axi_arburst,
  output logic                              m00_axi_arlock,
  output logic [3:0]                        m00_axi_arcache,
  output logic [2:0]                        m00_axi_arprot,
  output logic [3:0]                        m00_axi_arqos,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [5:0]                        m00_axi_rid,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rlast,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);
  localparam int PW = $clog2(max_outstanding_p);

  logic          aw_sel, aw_hs, ar_sel, ar_hs;
  logic          w_pop, wq_empty, wq_full, w_src;
  logic [5:0]    wq_mem [max_outstanding_p];
  logic [PW:0]   wq_wr, wq_rd;
  logic [5:0]    wq_head;

  m00_axi_arbiter_rr #(.max_outstanding_p(max_outstanding_p)) u_aw (
    .aclk(aclk), .areset(areset),
    .valid0(s0_axi_awvalid), .valid1(s1_axi_awvalid),
    .blocked(wq_full), .m_ready(m00_axi_awready),
    .dec(m00_axi_bvalid & m00_axi_bready),
    .sel(aw_sel), .m_valid(m00_axi_awvalid),
    .ready0(s0_axi_awready), .ready1(s1_axi_awready), .hs(aw_hs)
  );

  m00_axi_arbiter_rr #(.max_outstanding_p(max_outstanding_p)) u_ar (
    .aclk(aclk), .areset(areset),
    .valid0(s0_axi_arvalid), .valid1(s1_axi_arvalid),
    .blocked(1'b0), .m_ready(m00_axi_arready),
    .dec(m00_axi_rvalid & m00_axi_rready & m00_axi_rlast),
    .sel(ar_sel), .m_valid(m00_axi_arvalid),
    .ready0(s0_axi_arready), .ready1(s1_axi_arready), .hs(ar_hs)
  );

  assign m00_axi_awid    = {aw_sel, aw_sel ? s1_axi_awid : s0_axi_awid};
  assign m00_axi_awaddr  = aw_sel ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m00_axi_awlen   = aw_sel ? s1_axi_awlen   : s0_axi_awlen;
  assign m00_axi_awsize  = aw_sel ? s1_axi_awsize  : s0_axi_awsize;
  assign m00_axi_awburst = aw_sel ? s1_axi_awburst : s0_axi_awburst;
  assign m00_axi_awlock  = aw_sel ? s1_axi_awlock  : s0_axi_awlock;
  assign m00_axi_awcache = aw_sel ? s1_axi_awcache : s0_axi_awcache;
  assign m00_axi_awprot  = aw_sel ? s1_axi_awprot  : s0_axi_awprot;
  assign m00_axi_awqos   = aw_sel ? s1_axi_awqos   : s0_axi_awqos;

  assign m00_axi_arid    = {ar_sel, ar_sel ? s1_axi_arid : s0_axi_arid};
  assign m00_axi_araddr  = ar_sel ? s1_axi_araddr  : s0_axi_araddr;
  assign m00_axi_arlen   = ar_sel ? s1_axi_arlen   : s0_axi_arlen;
  assign m00_axi_arsize  = ar_sel ? s1_axi_arsize  : s0_axi_arsize;
  assign m00_axi_arburst = ar_sel ? s1_axi_arburst : s0_axi_arburst;
  assign m00_axi_arlock  = ar_sel ? s1_axi_arlock  : s0_axi_arlock;
  assign m00_axi_arcache = ar_sel ? s1_axi_arcache : s0_axi_arcache;
  assign m00_axi_arprot  = ar_sel ? s1_axi_arprot  : s0_axi_arprot;
  assign m00_axi_arqos   = ar_sel ? s1_axi_arqos   : s0_axi_arqos;

  // W-order FIFO: one extra pointer bit distinguishes full from empty.
  assign wq_empty = (wq_wr == wq_rd);
  assign wq_full  = (wq_wr[PW] != wq_rd[PW]) && (wq_wr[PW-1:0] == wq_rd[PW-1:0]);
  assign wq_head  = wq_mem[wq_rd[PW-1:0]];
  assign w_src    = wq_head[5];
  assign w_pop    = m00_axi_wvalid & m00_axi_wready & m00_axi_wlast;

  // FIFO pointers: push on AW handshake, pop on the last W beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wq_wr <= '0;
      wq_rd <= '0;
    end else begin
      if (aw_hs) wq_wr <= wq_wr + 1'b1;
      if (w_pop) wq_rd <= wq_rd + 1'b1;
    end
  end

  // FIFO storage holds the full tagged ID so m00_axi_wid needs no extra mux.
  always_ff @(posedge aclk) begin
    if (aw_hs) wq_mem[wq_wr[PW-1:0]] <= m00_axi_awid;
  end

  assign m00_axi_wid    = wq_head;
  assign m00_axi_wdata  = w_src ? s1_axi_wdata : s0_axi_wdata;
  assign m00_axi_wstrb  = w_src ? s1_axi_wstrb : s0_axi_wstrb;
  assign m00_axi_wlast  = w_src ? s1_axi_wlast : s0_axi_wlast;
  assign m00_axi_wvalid = ~wq_empty & (w_src ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready  = ~wq_empty & ~w_src & m00_axi_wready;
  assign s1_axi_wready  = ~wq_empty &  w_src & m00_axi_wready;

  assign s0_axi_bvalid  = m00_axi_bvalid & ~m00_axi_bid[5];
  assign s1_axi_bvalid  = m00_axi_bvalid &  m00_axi_bid[5];
  assign s0_axi_bid     = m00_axi_bid[4:0];
  assign s1_axi_bid     = m00_axi_bid[4:0];
  assign s0_axi_bresp   = m00_axi_bresp;
  assign s1_axi_bresp   = m00_axi_bresp;
  assign m00_axi_bready = m00_axi_bid[5] ? s1_axi_bready : s0_axi_bready;

  assign s0_axi_rvalid  = m00_axi_rvalid & ~m00_axi_rid[5];
  assign s1_axi_rvalid  = m00_axi_rvalid &  m00_axi_rid[5];
  assign s0_axi_rid     = m00_axi_rid[4:0];
  assign s1_axi_rid     = m00_axi_rid[4:0];
  assign s0_axi_rdata   = m00_axi_rdata;
  assign s1_axi_rdata   = m00_axi_rdata;
  assign s0_axi_rlast   = m00_axi_rlast;
  assign s1_axi_rlast   = m00_axi_rlast;
  assign s0_axi_rresp   = m00_axi_rresp;
  assign s1_axi_rresp   = m00_axi_rresp;
  assign m00_axi_rready = m00_axi_rid[5] ? s1_axi_rready : s0_axi_rready;
endmodule
